// File: rtl/multu_hilo.sv
// multu_hilo -- sequential unsigned multiplier with HI/LO register pair
// for the mMIPS execute stage. It starts when the ALU control code equals
// MULT_CODE. It retires one multiplier bit per cycle, so a multiply takes
// WIDTH cycles. The product is held in HI/LO until the next multiply
// completes.
//
// Ports:
//   clock    system clock, rising edge
//   reset    asynchronous, active-high clear of all state
//   ALUctrl  6-bit ALU control code of the instruction in execute
//   start    instruction in execute is valid
//   a, b     multiplicand (rs) and multiplier (rt)
//   hilo_rd  an mfhi/mflo needs HI/LO this cycle
//   hi, lo   upper / lower product halves
//   busy     multiply in progress
//   done     one-cycle pulse after HI/LO update
//   stall    interlock request (combinational)
module multu_hilo #(
   parameter int         WIDTH     = 32,
   parameter logic [5:0] MULT_CODE = 6'h13
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       ALUctrl,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             hilo_rd,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH:0]   acc;      // one extra bit keeps the adder carry
   logic [CW-1:0]    count;

   logic             is_mult;
   logic             launch;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH-1:0] mplier_nx;

   assign is_mult = (ALUctrl == MULT_CODE);
   assign launch  = start & is_mult & (state == IDLE);
   assign busy    = (state == RUN);
   assign stall   = busy & (hilo_rd | (start & is_mult));

   // One shift-add step. {acc, mplier} acts as a single 2*WIDTH+1 bit
   // register that shifts right. Product bits leave acc and enter the
   // top of mplier as the consumed multiplier bits leave at the bottom.
   always_comb begin
      sum       = mplier[0] ? (acc + {1'b0, mcand}) : acc;
      acc_nx    = sum >> 1;
      mplier_nx = {sum[0], mplier[WIDTH-1:1]};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         count  <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (launch) begin
                  mcand  <= a;
                  mplier <= b;
                  acc    <= '0;
                  count  <= '0;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc    <= acc_nx;
               mplier <= mplier_nx;
               count  <= count + 1'b1;
               // Final iteration: only the completed product reaches HI/LO.
               if (count == CW'(WIDTH - 1)) begin
                  hi    <= acc_nx[WIDTH-1:0];
                  lo    <= mplier_nx;
                  done  <= 1'b1;
                  count <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
